// File: rtl/affine_loop_ctrl_pkg.sv
// affine_loop_ctrl_pkg: shared types and helpers for the affine loop schedule controller.
package affine_loop_ctrl_pkg;

    localparam int CTRL_W_DEFAULT = 16;

    typedef logic [CTRL_W_DEFAULT-1:0] ctrl_idx_t;

    typedef enum logic [1:0] {WAIT, RUN, DONE} alc_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/affine_loop_ctrl_if.sv
// affine_loop_ctrl_if: schedule bus between the controller and its driver/consumer.
//   flush, en        : driver -> controller (synchronous restart, advance enable)
//   valid            : one-cycle strobe per loop iteration
//   ctrl_vars[2:0]   : registered indices, ctrl_vars[0] = dim0 (outermost)
//   done             : sticky completion flag
//   cycle_cnt, stall_cnt : only with AFFINE_LOOP_CTRL_CYCLE_CNT_EN defined
interface affine_loop_ctrl_if #(parameter int CTRL_W = 16);
    logic              flush;
    logic              en;
    logic              valid;
    logic              done;
    logic [CTRL_W-1:0] ctrl_vars [2:0];
`ifdef AFFINE_LOOP_CTRL_CYCLE_CNT_EN
    logic [31:0]       cycle_cnt;
    logic [31:0]       stall_cnt;
`endif

    modport master (
        input  flush, en,
`ifdef AFFINE_LOOP_CTRL_CYCLE_CNT_EN
        output cycle_cnt, stall_cnt,
`endif
        output valid, ctrl_vars, done
    );

    modport slave (
        output flush, en,
`ifdef AFFINE_LOOP_CTRL_CYCLE_CNT_EN
        input  cycle_cnt, stall_cnt,
`endif
        input  valid, ctrl_vars, done
    );

endinterface

// File: rtl/affine_wrap_ctr.sv
// affine_wrap_ctr: one loop index that wraps at extent-1 and reports a carry.
//   clk, rst   : clock, async active-high reset
//   clr_i      : synchronous clear (flush)
//   inc_i      : carry-in; this index would step on this slot
//   upd_i      : commit the step (enable and not the terminal slot)
//   extent_i   : trip count of this loop level
//   value_o    : registered index
//   carry_o    : inc_i while the index sits at extent-1
module affine_wrap_ctr #(parameter int CTRL_W = 16) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic              upd_i,
    input  logic [CTRL_W-1:0] extent_i,
    output logic [CTRL_W-1:0] value_o,
    output logic              carry_o
);
    localparam logic [CTRL_W-1:0] ONE = CTRL_W'(1);

    logic [CTRL_W-1:0] value_q, value_d;
    logic              at_max;

    assign at_max  = value_q == extent_i - ONE;
    assign carry_o = inc_i && at_max;
    assign value_o = value_q;

    always_comb value_d = clr_i ? '0 : !(inc_i && upd_i) ? value_q : at_max ? '0 : value_q + ONE;

    always_ff @(posedge clk or posedge rst)
        if (rst) value_q <= '0;
        else     value_q <= value_d;

endmodule

// File: rtl/affine_loop_ctrl.sv
// affine_loop_ctrl: start-delay / initiation-interval schedule over a 3-level nested loop.
//   clk, rst : clock, async active-high reset
//   bus      : affine_loop_ctrl_if.master (flush, en in; valid, ctrl_vars, done out)
//   Optional counters cycle_cnt/stall_cnt exist with AFFINE_LOOP_CTRL_CYCLE_CNT_EN defined.
module affine_loop_ctrl
    import affine_loop_ctrl_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int EXT0   = 1,
    parameter int EXT1   = 64,
    parameter int EXT2   = 64,
    parameter int START  = 0,
    parameter int II     = 1
) (
    input logic clk,
    input logic rst,
    affine_loop_ctrl_if.master bus
);
    typedef logic [CTRL_W-1:0] idx_t;

    localparam idx_t ONE     = idx_t'(1);
    localparam idx_t START_C = idx_t'(START);
    localparam idx_t II_C    = idx_t'(II);
    localparam idx_t EXT0_C  = idx_t'(EXT0);
    localparam idx_t EXT1_C  = idx_t'(EXT1);
    localparam idx_t EXT2_C  = idx_t'(EXT2);

    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0] state_q, state_d;
    idx_t       dly_q, dly_d, ii_q, ii_d;
    idx_t       idx0, idx1, idx2;
    logic       valid_q, valid_d, done_q, done_d;
    logic       ii_hit, slot, c2, c1, last, upd;

    // slot: this enabled edge would emit the next strobe in RUN; the chain's
    // final carry then means the current tuple was the last one.
    assign ii_hit = (ii_q + ONE) == II_C;
    assign slot   = (state_q == S_RUN) && ii_hit;
    assign upd    = bus.en && !last;

    affine_wrap_ctr #(.CTRL_W(CTRL_W)) u_dim2 (
        .clk(clk), .rst(rst), .clr_i(bus.flush), .inc_i(slot), .upd_i(upd),
        .extent_i(EXT2_C), .value_o(idx2), .carry_o(c2)
    );

    affine_wrap_ctr #(.CTRL_W(CTRL_W)) u_dim1 (
        .clk(clk), .rst(rst), .clr_i(bus.flush), .inc_i(c2), .upd_i(upd),
        .extent_i(EXT1_C), .value_o(idx1), .carry_o(c1)
    );

    affine_wrap_ctr #(.CTRL_W(CTRL_W)) u_dim0 (
        .clk(clk), .rst(rst), .clr_i(bus.flush), .inc_i(c1), .upd_i(upd),
        .extent_i(EXT0_C), .value_o(idx0), .carry_o(last)
    );

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        ii_d    = ii_q;
        valid_d = 1'b0;
        done_d  = done_q;
        if (bus.flush) begin
            state_d = S_WAIT;
            dly_d   = '0;
            ii_d    = '0;
            done_d  = 1'b0;
        end else if (bus.en && state_q == S_WAIT) begin
            state_d = (dly_q == START_C) ? S_RUN : S_WAIT;
            valid_d = dly_q == START_C;
            dly_d   = (dly_q == START_C) ? dly_q : dly_q + ONE;
        end else if (bus.en && state_q == S_RUN) begin
            ii_d    = ii_hit ? '0 : ii_q + ONE;
            valid_d = ii_hit && !last;
            done_d  = ii_hit && last;
            state_d = (ii_hit && last) ? S_DONE : S_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_WAIT;
            dly_q   <= '0;
            ii_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            ii_q    <= ii_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end

    assign bus.valid        = valid_q;
    assign bus.done         = done_q;
    assign bus.ctrl_vars[0] = idx0;
    assign bus.ctrl_vars[1] = idx1;
    assign bus.ctrl_vars[2] = idx2;

`ifdef AFFINE_LOOP_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_q, stall_q;

    // The edge that raises done is not counted, so the count freezes with done.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (bus.flush) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (bus.en && !done_d)              cyc_q   <= sat_inc32(cyc_q);
            if (!bus.en && state_q != S_DONE)   stall_q <= sat_inc32(stall_q);
        end

    assign bus.cycle_cnt = cyc_q;
    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_affine_loop_ctrl.sv
// tb_affine_loop_ctrl: scoreboard bench running three controller configurations in lockstep.
module tb_affine_loop_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    affine_loop_ctrl_if ifa ();
    affine_loop_ctrl_if ifb ();
    affine_loop_ctrl_if ifc ();

    affine_loop_ctrl u_a (.clk(clk), .rst(rst), .bus(ifa));
    affine_loop_ctrl #(.EXT0(1), .EXT1(2), .EXT2(2), .START(5), .II(3)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    affine_loop_ctrl #(.EXT0(1), .EXT1(1), .EXT2(1), .START(0), .II(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    logic [49:0] oa, ob, oc;
    assign oa = {ifa.valid, ifa.done, ifa.ctrl_vars[0], ifa.ctrl_vars[1], ifa.ctrl_vars[2]};
    assign ob = {ifb.valid, ifb.done, ifb.ctrl_vars[0], ifb.ctrl_vars[1], ifb.ctrl_vars[2]};
    assign oc = {ifc.valid, ifc.done, ifc.ctrl_vars[0], ifc.ctrl_vars[1], ifc.ctrl_vars[2]};

    logic [49:0] qa[$], qb[$], qc[$];
    int k, sa, sb, sc, n_chk, n_err;

    task automatic chk(input string tag, input logic [49:0] got, input logic [49:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Closed-form schedule: k = enabled edges since restart, strobe n lands on
    // edge st+1+n*ii, done on edge st+1+total*ii; indices hold the last strobe.
    function automatic logic [49:0] model(input int kk, input bit en_now, input int st, input int ii,
                                          input int e0, input int e1, input int e2);
        int total, m, n;
        bit v, d;
        total = e0 * e1 * e2;
        d = kk >= st + 1 + total * ii;
        v = en_now && kk >= st + 1 && ((kk - st - 1) % ii == 0) && ((kk - st - 1) / ii < total);
        m = (kk < st + 1) ? 0 : ((kk - st - 1) / ii + 1 > total ? total : (kk - st - 1) / ii + 1);
        n = (m == 0) ? 0 : m - 1;
        return {v, d, 16'(n / (e1 * e2)), 16'((n / e2) % e1), 16'(n % e2)};
    endfunction

    task automatic push_exp(input bit en_now);
        qa.push_back(model(k, en_now, 0, 1, 1, 64, 64));
        qb.push_back(model(k, en_now, 5, 3, 1, 2, 2));
        qc.push_back(model(k, en_now, 0, 1, 1, 1, 1));
    endtask

    task automatic pop_chk();
        chk("a_out", oa, qa.pop_front());
        chk("b_out", ob, qb.pop_front());
        chk("c_out", oc, qc.pop_front());
    endtask

    task automatic step(input bit e, input bit f);
        ifa.en = e; ifb.en = e; ifc.en = e;
        ifa.flush = f; ifb.flush = f; ifc.flush = f;
        if (f) k = 0;
        else if (e) k++;
        push_exp(e && !f);
        @(posedge clk);
        #1;
        pop_chk();
        if (ifa.valid) sa++;
        if (ifb.valid) sb++;
        if (ifc.valid) sc++;
    endtask

    task automatic arst();
        #2 rst = 1'b1;
        #1;
        k = 0;
        push_exp(1'b0);
        pop_chk();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifa.en = 1'b0; ifb.en = 1'b0; ifc.en = 1'b0;
        ifa.flush = 1'b0; ifb.flush = 1'b0; ifc.flush = 1'b0;
        k = 0; sa = 0; sb = 0; sc = 0; n_chk = 0; n_err = 0;
        #12;
        push_exp(1'b0);
        pop_chk();
        rst = 1'b0;

        repeat (4100) step(1'b1, 1'b0);
        chk("a_strobes_run", 50'(sa), 50'd4096);
        chk("b_strobes_run", 50'(sb), 50'd4);
        chk("c_strobes_run", 50'(sc), 50'd1);
`ifdef AFFINE_LOOP_CTRL_CYCLE_CNT_EN
        chk("c_cycle_cnt", 50'(ifc.cycle_cnt), 50'd1);
`endif

        step(1'b0, 1'b1);
        sa = 0; sb = 0;
        for (int c = 0; c < 8200; c++) step((c % 4 == 0) || (c % 4 == 3), 1'b0);
        chk("a_strobes_toggle", 50'(sa), 50'd4096);
        chk("b_strobes_toggle", 50'(sb), 50'd4);

        step(1'b0, 1'b1);
        while (k < 648) step(1'b1, 1'b0);
        chk("a_before_flush", oa, {2'b10, 16'd0, 16'd10, 16'd7});
        step(1'b1, 1'b1);
        sa = 0;
        repeat (4100) step(1'b1, 1'b0);
        chk("a_strobes_flush", 50'(sa), 50'd4096);

        repeat (300) step(1'b1, 1'b0);
        arst();
        sa = 0;
        repeat (4100) step(1'b1, 1'b0);
        chk("a_strobes_arst", 50'(sa), 50'd4096);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
